// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external memory responder: FSM state codes,
// read/write encoding and block-size helpers.
package ext_mem_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StWait  = 3'd1;
    localparam state_t StRead  = 3'd2;
    localparam state_t StWrite = 3'd3;
    localparam state_t StDone  = 3'd4;

    function automatic int unsigned log2_words(input int unsigned words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/ext_mem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// Read data changes only on a read enable, so it holds between reads.
module ext_mem_ram
    import ext_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 14
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_BITS-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_BITS];
    logic [31:0] rdata_q;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/external_memory_responder.sv
// Responder for the external memory bus: single/block reads and writes backed
// by on-chip RAM, with a fixed read latency before the first read word.
module external_memory_responder
    import ext_mem_pkg::*;
#(
    parameter int unsigned BW_WORD_ADDR = 24,
    parameter int unsigned DEPTH_BITS   = 14,
    parameter int unsigned BLOCK_WORDS  = 16,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    input  logic                    reqBlock_i,
    input  logic                    clear_i,
    input  logic                    rw_i,
    input  logic [BW_WORD_ADDR-1:0] add_i,
    input  logic [31:0]             data_i,
    output logic [31:0]             data_o,
    output logic                    done_o,
    output logic                    ready_o,
    output logic                    valid_o
);

    localparam int unsigned OffBits = log2_words(BLOCK_WORDS);
    localparam int unsigned CntW    = OffBits + 1;

    localparam logic [CntW-1:0]       BlockLen  = CntW'(BLOCK_WORDS);
    localparam logic [CntW-1:0]       OneWord   = CntW'(1);
    localparam logic [DEPTH_BITS-1:0] BlockMask = ~DEPTH_BITS'(BLOCK_WORDS - 1);
    localparam logic [DEPTH_BITS-1:0] AddrOne   = DEPTH_BITS'(1);
    localparam logic [3:0]            LatInit   =
        (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    state_t                state_q, state_d;
    logic [3:0]            lat_q, lat_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DEPTH_BITS-1:0] addr_q, addr_d;
    logic                  ready_q, valid_q, done_q;

    logic                  ram_we, ram_re;
    logic [DEPTH_BITS-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [DEPTH_BITS-1:0] req_base;
    logic [CntW-1:0]       req_len;

    // Address bits above the RAM depth alias onto the same words.
    logic unused_add_hi;
    assign unused_add_hi = ^add_i[BW_WORD_ADDR-1:DEPTH_BITS];

    assign req_base = add_i[DEPTH_BITS-1:0] & (reqBlock_i ? BlockMask : '1);
    assign req_len  = reqBlock_i ? BlockLen : OneWord;

    // addr_q always points at the next RAM word to touch; cnt_q counts words left.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = data_i;

        if (clear_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ready_q && req_i) begin
                        if (rw_i == RW_WRITE) begin
                            ram_we   = 1'b1;
                            ram_addr = req_base;
                            addr_d   = req_base + AddrOne;
                            cnt_d    = req_len - OneWord;
                            state_d  = reqBlock_i ? StWrite : StDone;
                        end else if (READ_LATENCY == 0) begin
                            // Prefetch word 0 now so it is on data_o next cycle.
                            ram_re   = 1'b1;
                            ram_addr = req_base;
                            addr_d   = req_base + AddrOne;
                            cnt_d    = req_len;
                            state_d  = StRead;
                        end else begin
                            addr_d  = req_base;
                            cnt_d   = req_len;
                            lat_d   = LatInit;
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (lat_q == 4'd0) begin
                        ram_re  = 1'b1;
                        addr_d  = addr_q + AddrOne;
                        state_d = StRead;
                    end else begin
                        lat_d = lat_q - 4'd1;
                    end
                end
                StRead: begin
                    if (cnt_q > OneWord) begin
                        ram_re = 1'b1;
                        addr_d = addr_q + AddrOne;
                        cnt_d  = cnt_q - OneWord;
                    end else begin
                        state_d = StDone;
                    end
                end
                StWrite: begin
                    ram_we = 1'b1;
                    addr_d = addr_q + AddrOne;
                    cnt_d  = cnt_q - OneWord;
                    if (cnt_q == OneWord) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            lat_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ready_q <= (state_d == StIdle);
            valid_q <= (state_d == StRead);
            done_q  <= (state_d == StDone);
        end
    end

    ext_mem_ram #(
        .DEPTH_BITS (DEPTH_BITS)
    ) u_ram (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (ram_we && !reset_i),
        .re_i    (ram_re && !reset_i),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (data_o)
    );

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_external_memory_responder.sv
// Self-checking bench for external_memory_responder: directed table, corner
// sequences and randomized transfers against an associative-array memory model.
module tb_external_memory_responder;

    localparam int unsigned L     = 2;
    localparam int unsigned BW    = 16;
    localparam int unsigned DB    = 14;
    localparam int          DEPTH = 1 << DB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        blk = 1'b0;
    logic        clr = 1'b0;
    logic        rw  = 1'b0;
    logic [23:0] add = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        done, ready, valid;

    external_memory_responder #(
        .BW_WORD_ADDR (24),
        .DEPTH_BITS   (DB),
        .BLOCK_WORDS  (BW),
        .READ_LATENCY (L)
    ) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .req_i      (req),
        .reqBlock_i (blk),
        .clear_i    (clr),
        .rw_i       (rw),
        .add_i      (add),
        .data_i     (din),
        .data_o     (dout),
        .done_o     (done),
        .ready_o    (ready),
        .valid_o    (valid)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_mem [int];
    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];

    typedef struct {
        bit          is_wr;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, ready, valid, done};
    endfunction

    function automatic int word_addr(input logic [23:0] a, input bit b, input int k);
        int unit;
        unit = b ? int'(BW) : 1;
        return (((int'(a) % DEPTH) / unit) * unit + k) % DEPTH;
    endfunction

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("wait_ready_timeout", 32'(ready), 32'd1);
    endtask

    // One full transfer, cycle-accurate against the documented timeline.
    task automatic xfer(input bit is_wr, input bit is_blk, input logic [23:0] a);
        int n;
        int idx;
        n = is_blk ? int'(BW) : 1;
        wait_ready();
        req = 1'b1; blk = is_blk; rw = is_wr; add = a; din = wbuf[0];
        @(negedge clk);
        req = 1'b0;
        chk("ready_drop", 32'(ready), 32'd0);
        if (is_wr) begin
            for (int k = 1; k < n; k++) begin
                din = wbuf[k];
                chk("wr_busy_flags", flags(), 32'd0);
                @(negedge clk);
            end
            chk("wr_done_flags", flags(), 32'b001);
            for (int k = 0; k < n; k++) model_mem[word_addr(a, is_blk, k)] = wbuf[k];
        end else begin
            for (int c = 0; c < int'(L); c++) begin
                chk("rd_wait_flags", flags(), 32'd0);
                @(negedge clk);
            end
            for (int k = 0; k < n; k++) begin
                chk("rd_valid_flags", flags(), 32'b010);
                rbuf[k] = dout;
                idx = word_addr(a, is_blk, k);
                if (model_mem.exists(idx)) chk("rd_data_model", dout, model_mem[idx]);
                @(negedge clk);
            end
            chk("rd_done_flags", flags(), 32'b001);
            chk("rd_data_hold", dout, rbuf[n-1]);
        end
        @(negedge clk);
        chk("back_idle_flags", flags(), 32'b100);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int vcount, dcount, guard, acc, rcyc;
        int exp_acc;
        logic [23:0] ra;

        vecs[0] = '{1'b1, 24'h000123, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 24'h000123, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 24'h004123, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 24'h000123, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 24'hFFFFFF, 32'hA5A5A5A5, 32'h0};
        vecs[5] = '{1'b0, 24'h003FFF, 32'h0,        32'hA5A5A5A5};
        vecs[6] = '{1'b0, 24'hC03FFF, 32'h0,        32'hA5A5A5A5};
        vecs[7] = '{1'b1, 24'h000000, 32'hFFFFFFFF, 32'h0};
        vecs[8] = '{1'b0, 24'h100000, 32'h0,        32'hFFFFFFFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_flags", flags(), 32'd0);
        chk("reset_data", dout, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", flags(), 32'b100);

        // Directed single-word table
        foreach (vecs[i]) begin
            wbuf[0] = vecs[i].wdata;
            xfer(vecs[i].is_wr, 1'b0, vecs[i].addr);
            if (!vecs[i].is_wr) chk("table_rdata", rbuf[0], vecs[i].exp);
        end

        // Block write at 0x45, block read from 0x4A
        for (int k = 0; k < 16; k++) wbuf[k] = 32'h100 + 32'(k);
        xfer(1'b1, 1'b1, 24'h000045);
        xfer(1'b0, 1'b1, 24'h00004A);
        for (int k = 0; k < 16; k++) chk("block_rdata", rbuf[k], 32'h100 + 32'(k));

        // Aliasing above the RAM depth
        for (int k = 0; k < 16; k++) wbuf[k] = 32'h2000 + 32'(k);
        xfer(1'b1, 1'b1, 24'h003FF0);
        for (int k = 0; k < 16; k++) wbuf[k] = 32'h3000 + 32'(k);
        xfer(1'b1, 1'b1, 24'h013FF0);
        xfer(1'b0, 1'b1, 24'h003FF0);
        for (int k = 0; k < 16; k++) chk("wrap_rdata", rbuf[k], 32'h3000 + 32'(k));

        // Clear on the 5th valid of a block read
        wait_ready();
        req = 1'b1; blk = 1'b1; rw = 1'b0; add = 24'h000040;
        @(negedge clk);
        req = 1'b0;
        vcount = 0; guard = 0;
        while (guard < 40) begin
            if (valid === 1'b1) vcount++;
            if (vcount == 5) break;
            @(negedge clk);
            guard++;
        end
        chk("clr_reached_5th", 32'(vcount), 32'd5);
        chk("clr_5th_data", dout, 32'h104);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_flags_next", flags(), 32'b100);
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1 || valid === 1'b1) dcount++;
            @(negedge clk);
        end
        chk("clr_quiet_after", 32'(dcount), 32'd0);
        xfer(1'b0, 1'b0, 24'h000040);
        chk("clr_followup_rdata", rbuf[0], 32'h100);

        // req_i held through busy periods: one accept per idle visit
        wait_ready();
        req = 1'b1; blk = 1'b0; rw = 1'b0; add = 24'h000123;
        acc = 0; rcyc = 0; vcount = 0;
        for (int c = 0; c < 15; c++) begin
            if (ready === 1'b1) rcyc++;
            if (done === 1'b1) acc++;
            if (valid === 1'b1) vcount++;
            @(negedge clk);
        end
        req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) acc++;
            if (valid === 1'b1) vcount++;
            @(negedge clk);
        end
        exp_acc = (15 + int'(L) + 1 + 2 - 1) / (int'(L) + 1 + 2);
        chk("held_req_dones", 32'(acc), 32'(exp_acc));
        chk("held_req_valids", 32'(vcount), 32'(exp_acc));
        chk("held_req_ready_visits", 32'(rcyc), 32'(exp_acc));

        // clear and req together while idle
        wait_ready();
        req = 1'b1; clr = 1'b1; rw = 1'b1; blk = 1'b0; add = 24'h000200;
        @(negedge clk);
        req = 1'b0; clr = 1'b0;
        chk("clr_req_not_accepted", flags(), 32'b100);
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1 || valid === 1'b1) dcount++;
            @(negedge clk);
        end
        chk("clr_req_no_done", 32'(dcount), 32'd0);

        // Reset after three words of a block write
        for (int k = 0; k < 16; k++) wbuf[k] = 32'h4000 + 32'(k);
        xfer(1'b1, 1'b1, 24'h000080);
        wait_ready();
        req = 1'b1; blk = 1'b1; rw = 1'b1; add = 24'h000080; din = 32'h5000;
        @(negedge clk);
        req = 1'b0; din = 32'h5001;
        @(negedge clk);
        din = 32'h5002;
        @(negedge clk);
        rst = 1'b1; din = 32'h5003;
        @(negedge clk);
        chk("rst_mid_flags", flags(), 32'd0);
        chk("rst_mid_data", dout, 32'd0);
        @(negedge clk);
        chk("rst_mid_still_low", flags(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", flags(), 32'b100);
        for (int k = 0; k < 3; k++) model_mem[word_addr(24'h80, 1'b1, k)] = 32'h5000 + 32'(k);
        xfer(1'b0, 1'b1, 24'h000080);
        for (int k = 0; k < 16; k++)
            chk("rst_mid_rdata", rbuf[k], (k < 3) ? 32'h5000 + 32'(k) : 32'h4000 + 32'(k));

        // Random traffic in a 256-word window reached through random upper bits
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            ra = {10'($urandom), 14'h1000 + 14'(b * 16)};
            xfer(1'b1, 1'b1, ra);
        end
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            ra = {10'($urandom), 14'h1000 + 14'($urandom_range(0, 255))};
            xfer(1'($urandom), 1'($urandom), ra);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
